demux_1xn_stream: RTL

Parametrised, registered 1-to-N demultiplexer for WIDTH-bit words, with a valid/ready handshake on the input and on every output channel. It is the successor to the combinational 1x2 demux. It adds N channels, a single-entry output register with back-pressure, an optional round-robin mode that ignores the select, and a saturating counter of words dropped for an out-of-range select. It sits between a single producer and N consumers in the datapath.

---
 rtl/demux_1xn_stream.sv | 109 ++++++++++
 1 files changed

// File: rtl/demux_1xn_stream.sv
// demux_1xn_stream: registered 1-to-N stream demultiplexer.
// A single holding register carries one word plus its destination channel.
// Select-driven (MODE 0) or round-robin (MODE 1) steering.
// Words whose select is out of range are counted in a saturating drop
// counter instead of being stored.
module demux_1xn_stream #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    parameter  int MODE  = 0,
    parameter  int CNT_W = 8,
    localparam int SW    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     i,
    input  logic [SW-1:0]        s,
    input  logic                 i_valid,
    output logic                 i_ready,
    output logic [N*WIDTH-1:0]   y,
    output logic [N-1:0]         y_valid,
    input  logic [N-1:0]         y_ready,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic [SW-1:0]        rr_ptr
);

    localparam logic [SW:0]    N_W      = (SW+1)'(N);
    localparam logic [SW-1:0]  LAST_CH  = SW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    dest_q, dest_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [SW-1:0]    rr_q, rr_d;

    logic             accept;
    logic             drain;
    logic             sel_ok;
    logic [SW-1:0]    dest_in;

    // A held word only blocks the input while its own consumer is stalled.
    assign i_ready = !full_q || y_ready[dest_q];
    assign accept  = i_valid && i_ready;
    assign drain   = full_q && y_ready[dest_q];
    assign dest_in = (MODE != 0) ? rr_q : s;
    // Round-robin never produces an out-of-range index.
    assign sel_ok  = (MODE != 0) || ({1'b0, s} < N_W);

    assign drop_cnt = drop_q;
    assign rr_ptr   = rr_q;

    // Next-state for the holding register, drop counter and round-robin pointer.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        dest_d = dest_q;
        drop_d = drop_q;
        rr_d   = rr_q;

        if (accept && sel_ok) begin
            // Covers both fill-from-empty and replace-on-drain without a bubble.
            full_d = 1'b1;
            data_d = i;
            dest_d = dest_in;
        end else if (drain) begin
            full_d = 1'b0;
            data_d = '0;
            dest_d = '0;
        end

        if (accept && !sel_ok && (drop_q != CNT_MAX)) begin
            drop_d = drop_q + 1'b1;
        end

        if ((MODE != 0) && accept) begin
            rr_d = (rr_q == LAST_CH) ? '0 : rr_q + 1'b1;
        end
    end

    // State registers; a held word is simply discarded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            dest_q <= '0;
            drop_q <= '0;
            rr_q   <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            dest_q <= dest_d;
            drop_q <= drop_d;
            rr_q   <= rr_d;
        end
    end

    // Steer the held word onto its channel slice; every other slice reads zero.
    always_comb begin
        y       = '0;
        y_valid = '0;
        for (int k = 0; k < N; k++) begin
            if (full_q && (dest_q == SW'(k))) begin
                y[k*WIDTH +: WIDTH] = data_q;
                y_valid[k]          = 1'b1;
            end
        end
    end

endmodule
